// File: rtl/if_id_skid_stage.sv
// ----------------------------------------------------------------------------
// if_id_skid_stage
//   IF->ID pipeline stage with a valid/ready handshake and a 2-entry skid
//   buffer. Carries {pc, instr, pc_plus_four} from fetch to decode. in_ready
//   is a register that depends only on the stage's own state, so there is no
//   combinational path from out_ready to in_ready. flush squashes everything
//   held back to a bubble.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous squash (branch/jump redirect)
//   in_valid/in_ready   fetch-side handshake
//   in_pc, in_instr, in_pc_plus_four    fetch payload
//   out_valid/out_ready decode-side handshake
//   out_pc, out_instr, out_pc_plus_four decode payload (MAIN register)
//   occupancy           number of held entries (0, 1 or 2)
// ----------------------------------------------------------------------------
module if_id_skid_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h00400000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc_plus_four,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_plus_four,
  output logic [1:0]      occupancy
);

  // Bubble pc+4 wraps modulo 2^XLEN.
  localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + XLEN'(4);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc_plus_four;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and load-enable decode. In FULL in_ready is low, so in_fire
  // cannot occur and incoming entries are ignored.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          // Decode stalled: park the younger entry behind MAIN.
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so that in_ready,
  // out_valid and occupancy are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= EMPTY;
      out_valid         <= 1'b0;
      in_ready          <= 1'b1;
      occupancy         <= 2'd0;
      out_pc            <= RESET_PC;
      out_instr         <= NOP_INSTR;
      out_pc_plus_four  <= RESET_PC4;
      skid_pc           <= RESET_PC;
      skid_instr        <= NOP_INSTR;
      skid_pc_plus_four <= RESET_PC4;
    end else if (flush) begin
      // Same-cycle in_fire is dropped; a same-cycle out_fire was already
      // taken by decode, so nothing needs to be preserved.
      state             <= EMPTY;
      out_valid         <= 1'b0;
      in_ready          <= 1'b1;
      occupancy         <= 2'd0;
      out_pc            <= RESET_PC;
      out_instr         <= NOP_INSTR;
      out_pc_plus_four  <= RESET_PC4;
      skid_pc           <= RESET_PC;
      skid_instr        <= NOP_INSTR;
      skid_pc_plus_four <= RESET_PC4;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      case (state_nxt)
        EMPTY:   occupancy <= 2'd0;
        FULL:    occupancy <= 2'd2;
        default: occupancy <= 2'd1;
      endcase
      if (load_main_in) begin
        out_pc           <= in_pc;
        out_instr        <= in_instr;
        out_pc_plus_four <= in_pc_plus_four;
      end else if (load_main_skid) begin
        out_pc           <= skid_pc;
        out_instr        <= skid_instr;
        out_pc_plus_four <= skid_pc_plus_four;
      end
      if (load_skid) begin
        skid_pc           <= in_pc;
        skid_instr        <= in_instr;
        skid_pc_plus_four <= in_pc_plus_four;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_skid_stage
//   Directed table of per-cycle vectors, hand-written reset sequences, a
//   wrap-around reset check on a second instance, and a randomized run
//   checked against a FIFO scoreboard.
// ----------------------------------------------------------------------------
module tb_if_id_skid_stage;

  localparam logic [31:0] RPC  = 32'h00400000;
  localparam logic [31:0] RPC4 = 32'h00400004;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] KEY  = 32'h12345673;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [31:0] in_pc_plus_four;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus_four;
  logic [1:0]  occupancy;

  // Second instance whose bubble pc+4 must wrap to zero.
  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc_plus_four;
  logic [1:0]  w_occupancy;

  int checks;
  int failures;

  if_id_skid_stage #(.XLEN(32), .RESET_PC(32'h00400000), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_pc_plus_four(in_pc_plus_four),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_pc_plus_four(out_pc_plus_four),
    .occupancy(occupancy)
  );

  if_id_skid_stage #(.XLEN(32), .RESET_PC(32'hFFFFFFFC), .NOP_INSTR(32'h00000013)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_pc_plus_four(in_pc_plus_four),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_out_pc), .out_instr(w_out_instr), .out_pc_plus_four(w_out_pc_plus_four),
    .occupancy(w_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    flush           = fl;
    in_valid        = iv;
    in_pc           = pc;
    in_instr        = pc ^ KEY;
    in_pc_plus_four = pc + 32'd4;
    out_ready       = ordy;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_occupancy"}, {30'd0, occupancy}, 32'd0);
    chk({tag, "_out_pc"},    out_pc,             RPC);
    chk({tag, "_out_instr"}, out_instr,          NOP);
    chk({tag, "_out_pc4"},   out_pc_plus_four,   RPC4);
  endtask

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        ev;
    logic        ir;
    logic [1:0]  occ;
    logic [31:0] epc;
    logic        nop;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                              input logic ordy, input logic ev, input logic ir,
                              input logic [1:0] occ, input logic [31:0] epc, input logic nop);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.ev = ev; v.ir = ir; v.occ = occ; v.epc = epc; v.nop = nop;
    return v;
  endfunction

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  // Scoreboard state for the randomized run.
  logic [31:0] q[$];
  logic [31:0] exp_pc;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc4;
  logic        prev_stall;
  logic [31:0] seq_pc;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    //        fl iv  pc            ordy ev  ir  occ  epc           nop
    // streaming
    tbl[0]  = mk(0, 1, 32'h00400000, 1, 1, 1, 2'd1, 32'h00400000, 0);
    tbl[1]  = mk(0, 1, 32'h00400004, 1, 1, 1, 2'd1, 32'h00400004, 0);
    tbl[2]  = mk(0, 1, 32'h00400008, 1, 1, 1, 2'd1, 32'h00400008, 0);
    tbl[3]  = mk(0, 0, 32'h0,        1, 0, 1, 2'd0, 32'h00400008, 0);
    // back-pressure A then B, extra offer ignored while full
    tbl[4]  = mk(0, 1, 32'h00001000, 0, 1, 1, 2'd1, 32'h00001000, 0);
    tbl[5]  = mk(0, 1, 32'h00002000, 0, 1, 0, 2'd2, 32'h00001000, 0);
    tbl[6]  = mk(0, 1, 32'h00003000, 0, 1, 0, 2'd2, 32'h00001000, 0);
    tbl[7]  = mk(0, 0, 32'h0,        1, 1, 1, 2'd1, 32'h00002000, 0);
    tbl[8]  = mk(0, 0, 32'h0,        1, 0, 1, 2'd0, 32'h00002000, 0);
    // flush while FULL with a same-cycle offer of C=0x6000
    tbl[9]  = mk(0, 1, 32'h00004000, 0, 1, 1, 2'd1, 32'h00004000, 0);
    tbl[10] = mk(0, 1, 32'h00005000, 0, 1, 0, 2'd2, 32'h00004000, 0);
    tbl[11] = mk(1, 1, 32'h00006000, 0, 0, 1, 2'd0, RPC,          1);
    tbl[12] = mk(0, 1, 32'h00007000, 0, 1, 1, 2'd1, 32'h00007000, 0);
    tbl[13] = mk(0, 0, 32'h0,        1, 0, 1, 2'd0, 32'h00007000, 0);
    // flush held for several cycles drops every offer
    tbl[14] = mk(0, 1, 32'h00008000, 0, 1, 1, 2'd1, 32'h00008000, 0);
    tbl[15] = mk(1, 1, 32'h00009000, 1, 0, 1, 2'd0, RPC,          1);
    tbl[16] = mk(1, 1, 32'h0000A000, 0, 0, 1, 2'd0, RPC,          1);
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 1, 2'd0, RPC,          1);
    // FULL drains while fetch keeps offering, then full-throughput refill
    tbl[18] = mk(0, 1, 32'h0000B000, 0, 1, 1, 2'd1, 32'h0000B000, 0);
    tbl[19] = mk(0, 1, 32'h0000C000, 0, 1, 0, 2'd2, 32'h0000B000, 0);
    tbl[20] = mk(0, 1, 32'h0000D000, 1, 1, 1, 2'd1, 32'h0000C000, 0);
    tbl[21] = mk(0, 1, 32'h0000E000, 1, 1, 1, 2'd1, 32'h0000E000, 0);
    tbl[22] = mk(0, 0, 32'h0,        1, 0, 1, 2'd0, 32'h0000E000, 0);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk_bubble("reset");
    chk("wrap_out_pc4", w_out_pc_plus_four, 32'h00000000);
    chk("wrap_out_pc",  w_out_pc,           32'hFFFFFFFC);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].ir});
      chk($sformatf("vec%0d_occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].occ});
      chk($sformatf("vec%0d_out_pc", i),    out_pc,             tbl[i].epc);
      chk($sformatf("vec%0d_out_instr", i), out_instr,
          tbl[i].nop ? NOP : (tbl[i].epc ^ KEY));
      chk($sformatf("vec%0d_out_pc4", i),   out_pc_plus_four,
          tbl[i].nop ? RPC4 : (tbl[i].epc + 32'd4));
    end

    // Reset mid-transfer: fill to FULL, then assert rst_n with handshakes live.
    drive(1'b0, 1'b1, 32'h00010000, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h00020000, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_occupancy", {30'd0, occupancy}, 32'd2);
    drive(1'b1, 1'b1, 32'h00030000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_bubble("midreset_now");
    @(posedge clk); #1;
    chk_bubble("midreset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk_bubble("midreset_after");

    // Randomized run against a FIFO scoreboard.
    q.delete();
    prev_stall = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    prev_pc4   = '0;
    seq_pc     = 32'h10000000;
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), seq_pc,
            ($urandom_range(0, 9) < 6));
      @(negedge clk);
      chk("rand_occupancy", {30'd0, occupancy}, q.size());
      chk("rand_out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
      chk("rand_in_ready",  {31'd0, in_ready},  {31'd0, (q.size() < 2)});
      if (prev_stall) begin
        chk("rand_stable_pc",    out_pc,           prev_pc);
        chk("rand_stable_instr", out_instr,        prev_instr);
        chk("rand_stable_pc4",   out_pc_plus_four, prev_pc4);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rand_spurious actual=0x%08h expected=none at %0t", out_pc, $time);
        end else begin
          exp_pc = q.pop_front();
          chk("rand_order_pc",    out_pc,           exp_pc);
          chk("rand_order_instr", out_instr,        exp_pc ^ KEY);
          chk("rand_order_pc4",   out_pc_plus_four, exp_pc + 32'd4);
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back(in_pc);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      prev_pc4   = out_pc_plus_four;
      if (in_valid) seq_pc = seq_pc + 32'd4;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
